// File: rtl/turn_signal_ctrl.sv
// Turn-signal controller: left/right/hazard blinking with optional auto-stop after N blinks.
// Hazard support is compiled in only when the TSC_HAZARD_EN macro is defined.
module turn_signal_ctrl #(
  parameter int unsigned HALF_PERIOD = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned AUTO_OFF    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             left_req,
  input  logic             right_req,
  input  logic             hazard_req,
  input  logic             off_req,
  output logic [2:0]       o_state,
  output logic             left_lamp,
  output logic             right_lamp,
  output logic [CNT_W-1:0] blink_cnt,
  output logic             done
);

`ifdef TSC_HAZARD_EN
  localparam bit HazardEn = 1'b1;
`else
  localparam bit HazardEn = 1'b0;
`endif

  localparam int unsigned      PhW     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PhW-1:0]   PhLast  = PhW'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] AutoCnt = CNT_W'(AUTO_OFF);
  localparam bit               AutoEn  = (AUTO_OFF != 0);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLeft   = 3'd1,
    StRight  = 3'd2,
    StHazard = 3'd3,
    StFinish = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PhW-1:0]   phase_q, phase_d;
  logic             lamp_q, lamp_d;
  logic             left_q, left_d;
  logic             right_q, right_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             auto_stop;
  logic             opp_req;
  logic             active_d;

  // Stop only once the final off-phase has fully elapsed.
  assign auto_stop = AutoEn && (cnt_q == AutoCnt) && !lamp_q && (phase_q == PhLast);
  assign opp_req   = (state_q == StLeft) ? right_req : left_req;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (HazardEn && hazard_req)       state_d = StHazard;
        else if (left_req && !right_req)  state_d = StLeft;
        else if (right_req && !left_req)  state_d = StRight;
      end
      StLeft, StRight: begin
        if (off_req)                      state_d = StFinish;
        else if (HazardEn && hazard_req)  state_d = StHazard;
        else if (opp_req)                 state_d = (state_q == StLeft) ? StRight : StLeft;
        else if (auto_stop)               state_d = StFinish;
      end
      StHazard: begin
        if (off_req) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    phase_d  = '0;
    lamp_d   = 1'b0;
    cnt_d    = cnt_q;
    active_d = (state_d == StLeft) || (state_d == StRight) || (state_d == StHazard);
    if (active_d && (state_d != state_q)) begin
      // Any mode entry, including a direction change, starts a fresh on-phase.
      lamp_d = 1'b1;
      cnt_d  = CNT_W'(1);
    end else if (active_d) begin
      if (phase_q == PhLast) begin
        lamp_d = !lamp_q;
        if (!lamp_q && (cnt_q != CntMax)) cnt_d = cnt_q + 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
        lamp_d  = lamp_q;
      end
    end else if (state_d == StIdle) begin
      cnt_d = '0;
    end
    left_d  = lamp_d && ((state_d == StLeft) || (state_d == StHazard));
    right_d = lamp_d && ((state_d == StRight) || (state_d == StHazard));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      phase_q <= '0;
      lamp_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      lamp_q  <= lamp_d;
      left_q  <= left_d;
      right_q <= right_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_state    = state_q;
  assign left_lamp  = left_q;
  assign right_lamp = right_q;
  assign blink_cnt  = cnt_q;
  assign done       = (state_q == StFinish);

endmodule
